// File: rtl/zigzag_pkg.sv
// Shared constants for the zigzag read-address controller.
//   BLK_SIZE : coefficients per 8x8 block
//   ADDR_W   : address width within one bank
//   ZZ       : JPEG zigzag map, ZZ[k] = raster index of the k-th coefficient
//              in zigzag scan order
package zigzag_pkg;

  localparam int BLK_SIZE = 64;
  localparam int ADDR_W   = 6;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BLK_SIZE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  localparam logic [ADDR_W-1:0] ZZ [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zigzag_rom.sv
// Combinational zigzag lookup.
//   idx  : position in zigzag scan order (0..63)
//   addr : raster address of that coefficient
module zigzag_rom
  import zigzag_pkg::*;
(
  input  logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] addr
);

  assign addr = ZZ[idx];

endmodule

// File: rtl/zigzag_ctrl.sv
// Ping-pong address controller for an external 2x64 coefficient buffer.
// Coefficients are written in raster order into one bank while the other
// bank is read out in zigzag (ZZ_EN=1) or raster (ZZ_EN=0) order.
//   clk, rst, flush        : clock, sync active-high reset, sync abort
//   in_valid / in_ready    : upstream handshake
//   wr_en, wr_bank, wr_addr: write strobe and address into the buffer
//   out_valid / out_ready  : downstream handshake
//   rd_bank, rd_addr       : read address into the buffer
//   out_last               : current read is the final one of its block
//   busy                   : a bank is full or a block is partially written
module zigzag_ctrl
  import zigzag_pkg::*;
#(
  parameter int ZZ_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              out_last,
  output logic              busy
);

  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] rcnt;
  logic [ADDR_W-1:0] zz_addr;
  logic              rd_xfer;
  logic              wr_done;
  logic              rd_done;

  zigzag_rom u_rom (
    .idx  (rcnt),
    .addr (zz_addr)
  );

  // in_ready looks only at the registered full flag, so a bank released by
  // the read side cannot be written in that same cycle.
  assign in_ready  = ~full[wr_bank];
  assign wr_en     = in_valid & in_ready;
  assign wr_addr   = wcnt;
  assign out_valid = full[rd_bank];
  assign rd_xfer   = out_valid & out_ready;
  assign rd_addr   = (ZZ_EN != 0) ? zz_addr : rcnt;
  assign out_last  = out_valid & (rcnt == ADDR_LAST);
  assign busy      = (|full) | (wcnt != '0);

  assign wr_done = wr_en & (wcnt == ADDR_LAST);
  assign rd_done = rd_xfer & (rcnt == ADDR_LAST);

  // Set and clear always target different banks: a write needs its bank
  // empty, a read needs its bank full.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst | flush) begin
      full    <= 2'b00;
      wcnt    <= '0;
      rcnt    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_en)   wcnt    <= wcnt + ADDR_ONE;
      if (wr_done) wr_bank <= ~wr_bank;
      if (rd_xfer) rcnt    <= rcnt + ADDR_ONE;
      if (rd_done) rd_bank <= ~rd_bank;
    end
  end

endmodule

// File: tb/tb_zigzag_ctrl.sv
// Bench for zigzag_ctrl: two instances (zigzag and raster) share stimulus;
// a block-level reference model (counts of filled/drained blocks and
// positions within the current block) predicts every output.
module tb_zigzag_ctrl;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;

  always #5 clk = ~clk;

  logic       a_in_ready, a_wr_en, a_wr_bank, a_out_valid, a_rd_bank, a_out_last, a_busy;
  logic [5:0] a_wr_addr, a_rd_addr;
  logic       b_in_ready, b_wr_en, b_wr_bank, b_out_valid, b_rd_bank, b_out_last, b_busy;
  logic [5:0] b_wr_addr, b_rd_addr;

  zigzag_ctrl #(.ZZ_EN(1)) dut_zz (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .wr_en(a_wr_en), .wr_bank(a_wr_bank), .wr_addr(a_wr_addr), .out_valid(a_out_valid),
    .out_ready(out_ready), .rd_bank(a_rd_bank), .rd_addr(a_rd_addr),
    .out_last(a_out_last), .busy(a_busy)
  );

  zigzag_ctrl #(.ZZ_EN(0)) dut_raster (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .wr_en(b_wr_en), .wr_bank(b_wr_bank), .wr_addr(b_wr_addr), .out_valid(b_out_valid),
    .out_ready(out_ready), .rd_bank(b_rd_bank), .rd_addr(b_rd_addr),
    .out_last(b_out_last), .busy(b_busy)
  );

  // {in_ready, wr_en, wr_bank, wr_addr, out_valid, rd_bank, rd_addr, out_last, busy}
  logic [18:0] a_vec, b_vec;
  assign a_vec = {a_in_ready, a_wr_en, a_wr_bank, a_wr_addr, a_out_valid, a_rd_bank, a_rd_addr, a_out_last, a_busy};
  assign b_vec = {b_in_ready, b_wr_en, b_wr_bank, b_wr_addr, b_out_valid, b_rd_bank, b_rd_addr, b_out_last, b_busy};

  localparam logic [18:0] POST_RST_IV1 = 19'b1_1_0_000000_0_0_000000_0_0;

  int n_cmp = 0;
  int n_err = 0;

  // Reference zigzag table built by walking the anti-diagonals of an 8x8 grid.
  int zz_ref [64];

  // Model state: blocks waiting to be drained, blocks written/read so far,
  // and the position inside the block currently being written/read.
  int m_nfull, m_wblk, m_wpos, m_rblk, m_rpos;

  function automatic void build_zz();
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_ref[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_ref[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  function automatic logic [18:0] exp_vec(input bit zigzag);
    logic       e_ir, e_ov;
    logic [5:0] e_ra;
    e_ir = (m_nfull < 2);
    e_ov = (m_nfull > 0);
    e_ra = zigzag ? 6'(zz_ref[m_rpos]) : 6'(m_rpos);
    return {e_ir, in_valid & e_ir, 1'(m_wblk % 2), 6'(m_wpos), e_ov, 1'(m_rblk % 2), e_ra,
            e_ov & (m_rpos == 63), (m_nfull > 0) || (m_wpos != 0)};
  endfunction

  function automatic void model_clear();
    m_nfull = 0; m_wblk = 0; m_wpos = 0; m_rblk = 0; m_rpos = 0;
  endfunction

  // Advance one clock; inputs are held from the preceding negedge.
  task automatic tick();
    bit wr, rd;
    wr = in_valid && (m_nfull < 2);
    rd = out_ready && (m_nfull > 0);
    @(posedge clk);
    if (rst || flush) begin
      model_clear();
    end else begin
      if (wr) begin
        m_wpos++;
        if (m_wpos == 64) begin m_wpos = 0; m_wblk++; m_nfull++; end
      end
      if (rd) begin
        m_rpos++;
        if (m_rpos == 64) begin m_rpos = 0; m_rblk++; m_nfull--; end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input bit use_flush);
    in_valid = 1'b0; out_ready = 1'b0;
    if (use_flush) flush = 1'b1; else rst = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b1;
    #1;
    n_cmp++;
    if (a_vec !== POST_RST_IV1) begin
      n_err++; $display("FAIL reset_outputs got %b want %b", a_vec, POST_RST_IV1);
    end
    n_cmp++;
    if (a_vec !== exp_vec(1'b1)) begin
      n_err++; $display("FAIL reset_model got %b want %b", a_vec, exp_vec(1'b1));
    end
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (a_wr_en !== 1'b0) begin
      n_err++; $display("FAIL reset_wr_en_follows got %b want 0", a_wr_en);
    end
  endtask

  task automatic test_single_block();
    int guard, nlast;
    int seq [$];
    do_reset(1'b0);
    out_ready = 1'b1;
    guard = 0;
    while (m_wblk == 0 && guard < 400) begin
      in_valid = ($urandom_range(3) != 0);
      #1;
      n_cmp++;
      if (a_vec !== exp_vec(1'b1)) begin
        n_err++; $display("FAIL single_fill got %b want %b", a_vec, exp_vec(1'b1));
      end
      tick(); guard++;
    end
    n_cmp++;
    if (m_wblk == 0) begin n_err++; $display("FAIL single_fill_timeout got %0d want 64 writes", m_wpos); end
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (a_out_valid !== 1'b1) begin
      n_err++; $display("FAIL single_valid_rise got %b want 1", a_out_valid);
    end
    nlast = 0; guard = 0;
    while (m_rblk == 0 && guard < 200) begin
      out_ready = ($urandom_range(3) != 0);
      #1;
      n_cmp++;
      if (a_vec !== exp_vec(1'b1)) begin
        n_err++; $display("FAIL single_drain got %b want %b", a_vec, exp_vec(1'b1));
      end
      if (a_out_valid && out_ready) begin
        seq.push_back(int'(a_rd_addr));
        if (a_out_last) nlast++;
      end
      tick(); guard++;
    end
    n_cmp++;
    if (seq.size() != 64 || nlast != 1) begin
      n_err++; $display("FAIL single_counts got reads=%0d last=%0d want 64/1", seq.size(), nlast);
    end
    for (int i = 0; i < seq.size() && i < 64; i++) begin
      n_cmp++;
      if (seq[i] != zz_ref[i]) begin
        n_err++; $display("FAIL single_zz[%0d] got %0d want %0d", i, seq[i], zz_ref[i]);
      end
    end
    #1;
    n_cmp++;
    if (a_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_idle got %b want 0", a_busy); end
  endtask

  task automatic test_streaming();
    do_reset(1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 320; c++) begin
      in_valid = (c < 256);
      #1;
      n_cmp++;
      if (a_vec !== exp_vec(1'b1)) begin
        n_err++; $display("FAIL stream_c%0d got %b want %b", c, a_vec, exp_vec(1'b1));
      end
      if (c >= 64 && c < 256) begin
        n_cmp++;
        if (!(a_wr_en && a_out_valid) || a_rd_bank !== 1'(((c - 64) / 64) % 2) || a_wr_bank !== 1'((c / 64) % 2)) begin
          n_err++;
          $display("FAIL stream_rate_c%0d got wr=%b rd=%b wb=%b rb=%b want 1/1/%0d/%0d",
                   c, a_wr_en, a_out_valid, a_wr_bank, a_rd_bank, (c / 64) % 2, ((c - 64) / 64) % 2);
        end
      end
      tick();
    end
  endtask

  task automatic test_full_stall();
    do_reset(1'b0);
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 130; c++) begin
      #1;
      n_cmp++;
      if (a_vec !== exp_vec(1'b1)) begin
        n_err++; $display("FAIL stall_fill_c%0d got %b want %b", c, a_vec, exp_vec(1'b1));
      end
      if (c == 127 || c == 128) begin
        n_cmp++;
        if (a_in_ready !== (c == 127)) begin
          n_err++; $display("FAIL stall_in_ready_c%0d got %b want %0d", c, a_in_ready, c == 127);
        end
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 65; c++) begin
      #1;
      n_cmp++;
      if (a_vec !== exp_vec(1'b1)) begin
        n_err++; $display("FAIL stall_drain_c%0d got %b want %b", c, a_vec, exp_vec(1'b1));
      end
      if (c == 63 || c == 64) begin
        n_cmp++;
        if (a_in_ready !== (c == 64)) begin
          n_err++; $display("FAIL stall_release_c%0d got %b want %0d", c, a_in_ready, c == 64);
        end
      end
      if (c < 64) tick();
    end
  endtask

  task automatic test_backpressure();
    logic       p_stall, p_bank;
    logic [5:0] p_addr;
    do_reset(1'b0);
    p_stall = 1'b0; p_bank = 1'b0; p_addr = '0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(4) != 0);
      out_ready = ($urandom_range(1) != 0);
      #1;
      n_cmp++;
      if (a_vec !== exp_vec(1'b1)) begin
        n_err++; $display("FAIL bp_c%0d got %b want %b", c, a_vec, exp_vec(1'b1));
      end
      if (p_stall) begin
        n_cmp++;
        if (a_rd_addr !== p_addr || a_rd_bank !== p_bank || a_out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL bp_hold_c%0d got addr=%0d bank=%b vld=%b want addr=%0d bank=%b vld=1",
                   c, a_rd_addr, a_rd_bank, a_out_valid, p_addr, p_bank);
        end
      end
      p_stall = a_out_valid & ~out_ready;
      p_addr  = a_rd_addr;
      p_bank  = a_rd_bank;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    for (int mode = 0; mode < 2; mode++) begin
      do_reset(1'b0);
      in_valid = 1'b1; out_ready = 1'b0;
      for (int c = 0; c < 30; c++) tick();
      #1;
      n_cmp++;
      if (a_wr_addr !== 6'd30 || a_busy !== 1'b1) begin
        n_err++; $display("FAIL midrst%0d_pre got addr=%0d busy=%b want 30/1", mode, a_wr_addr, a_busy);
      end
      if (mode == 0) rst = 1'b1; else flush = 1'b1;
      tick();
      rst = 1'b0; flush = 1'b0;
      #1;
      n_cmp++;
      if (a_vec !== POST_RST_IV1) begin
        n_err++; $display("FAIL midrst%0d_post got %b want %b", mode, a_vec, POST_RST_IV1);
      end
      for (int c = 0; c < 64; c++) begin
        #1;
        n_cmp++;
        if (a_vec !== exp_vec(1'b1)) begin
          n_err++; $display("FAIL midrst%0d_c%0d got %b want %b", mode, c, a_vec, exp_vec(1'b1));
        end
        tick();
      end
      in_valid = 1'b0;
      #1;
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_rd_bank !== 1'b0 || a_wr_bank !== 1'b1) begin
        n_err++;
        $display("FAIL midrst%0d_block got vld=%b rb=%b wb=%b want 1/0/1", mode, a_out_valid, a_rd_bank, a_wr_bank);
      end
    end
  endtask

  task automatic test_raster();
    int expect_idx;
    do_reset(1'b1);
    in_valid = 1'b1; out_ready = 1'b1;
    expect_idx = 0;
    for (int c = 0; c < 130; c++) begin
      in_valid = (c < 64);
      #1;
      n_cmp++;
      if (b_vec !== exp_vec(1'b0)) begin
        n_err++; $display("FAIL raster_c%0d got %b want %b", c, b_vec, exp_vec(1'b0));
      end
      if (b_out_valid) begin
        n_cmp++;
        if (int'(b_rd_addr) != expect_idx) begin
          n_err++; $display("FAIL raster_addr got %0d want %0d", b_rd_addr, expect_idx);
        end
        expect_idx++;
      end
      tick();
    end
    n_cmp++;
    if (expect_idx != 64) begin
      n_err++; $display("FAIL raster_count got %0d want 64", expect_idx);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    build_zz();
    model_clear();
    @(negedge clk);
    test_reset();
    test_single_block();
    test_streaming();
    test_full_stall();
    test_backpressure();
    test_mid_reset();
    test_raster();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zigzag_ctrl.md
ZIGZAG_CTRL -- requirements
Module: zigzag_ctrl

Interface
REQ-001 Parameter ZZ_EN, default 1: 1 = read addresses in JPEG zigzag order; 0 = raster order (bypass).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  synchronous abort; discards all buffered and partial blocks.
REQ-005 in_valid  input  1  upstream has a raster-order coefficient.
REQ-006 in_ready  output  1  controller accepts a coefficient this cycle.
REQ-007 wr_en  output  1  write strobe to the external 2x64 coefficient buffer.
REQ-008 wr_bank  output  1  bank being filled.
REQ-009 wr_addr  output  6  raster write address within wr_bank.
REQ-010 out_valid  output  1  a read address is presented.
REQ-011 out_ready  input  1  downstream consumes the addressed coefficient.
REQ-012 rd_bank  output  1  bank being drained.
REQ-013 rd_addr  output  6  read address within rd_bank.
REQ-014 out_last  output  1  current read is the 64th of the block.
REQ-015 busy  output  1  any bank full or partial write in progress.

Function
REQ-016 State: full[1:0], wcnt[5:0], rcnt[5:0], wr_bank, rd_bank. No other architectural state.
REQ-017 in_ready = !full[wr_bank]; wr_en = in_valid & in_ready; wr_addr = wcnt.
REQ-018 On a write transfer, wcnt SHALL increment; when wcnt==63, it SHALL wrap to 0, full[wr_bank] SHALL set, and wr_bank SHALL toggle.
REQ-019 out_valid = full[rd_bank]; rd_addr = ZZ_EN ? ZZ[rcnt] : rcnt; out_last = out_valid & (rcnt==63).
REQ-020 On a read transfer (out_valid & out_ready), rcnt SHALL increment; when rcnt==63, it SHALL wrap to 0, full[rd_bank] SHALL clear, and rd_bank SHALL toggle.
REQ-021 ZZ SHALL be the standard JPEG zigzag map: ZZ[0..9] = 0,1,8,16,9,2,3,10,17,24; ZZ[62] = 62; ZZ[63] = 63; ZZ SHALL be a permutation of 0..63.
REQ-022 Latency: out_valid SHALL rise the cycle after the 64th write transfer of a block, when that bank is rd_bank.
REQ-023 Throughput: with in_valid and out_ready held high, both sides SHALL sustain 1 transfer/cycle with zero bubbles after the first block fill.
REQ-024 Backpressure: while out_valid & !out_ready, rd_bank and rd_addr SHALL hold stable.
REQ-025 Both banks full: in_ready = 0 until the read-side release of REQ-020.
REQ-026 Same-cycle write-set and read-clear on different banks SHALL both take effect; the same bank cannot be both set and cleared (REQ-017/019 make them exclusive).
REQ-027 Read-side release and write acceptance into the released bank SHALL NOT occur in the same cycle (in_ready uses the registered full).
REQ-028 busy = |full | (wcnt != 0).
REQ-029 flush SHALL behave exactly as rst; flush and rst have equal effect and no priority difference.

Reset
REQ-030 On rst or flush: full=0, wcnt=0, rcnt=0, wr_bank=0, rd_bank=0.
REQ-031 Post-reset outputs: in_ready=1, wr_en=in_valid, wr_addr=0, out_valid=0, out_last=0, rd_addr=0, rd_bank=0, busy=0.
REQ-032 Reset mid-block SHALL discard the partial write and any undrained bank; the next accepted coefficient SHALL be written to bank 0, address 0.

Structure
REQ-033 Package zigzag_pkg SHALL hold BLK_SIZE=64, ADDR_W=6, and the 64-entry ZZ constant table.
REQ-034 Sub-module zigzag_rom (combinational 6-bit in, 6-bit out, indexes ZZ) SHALL implement the map; zigzag_ctrl SHALL instantiate it once.
REQ-035 No buffer storage inside zigzag_ctrl; the coefficient RAM is external.

Verification
REQ-036 Single block: 64 writes with out_ready=1 -> out_valid rises the cycle after the 64th write; rd_addr sequence equals ZZ[0..63]; out_last only on the 64th read; busy returns to 0.
REQ-037 Streaming: 4 blocks with in_valid=1 and out_ready=1 -> after the first 64 cycles, exactly 1 write and 1 read every cycle; banks alternate 0,1,0,1.
REQ-038 Full stall: out_ready=0 while 128 writes are offered -> in_ready drops after write 128; raising out_ready for 64 cycles -> in_ready returns the cycle after the 64th read.
REQ-039 Backpressure: toggle out_ready randomly -> rd_addr and rd_bank stable during stalls; the completed sequence still equals ZZ.
REQ-040 Mid-block reset: assert rst (then, separately, flush) after 30 writes -> outputs match REQ-031 next cycle; the next block starts at bank 0, address 0.
REQ-041 ZZ_EN=0: one block -> rd_addr = 0..63 in order.
